// File: rtl/nec_pkg.sv
// Shared definitions for the NEC IR command controller: event codes,
// FSM state encoding, event record width and the byte bit-reverse helper.
package nec_pkg;

  localparam int EVT_W = 34;

  localparam logic [1:0] EVT_PRESS   = 2'b00;
  localparam logic [1:0] EVT_REPEAT  = 2'b01;
  localparam logic [1:0] EVT_RELEASE = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HELD = 1'b1
  } state_t;

  // NEC sends LSB first, so each received byte arrives bit-reversed.
  function automatic logic [7:0] bit_rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = b[7-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/nec_evt_fifo.sv
// Synchronous event FIFO with valid/ready head, full flag and wrap-bit pointers.
// A push while full is accepted only if the head is popped in the same cycle.
module nec_evt_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 34
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_pop;
  logic             w_wr;

  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_valid = (r_wptr != r_rptr);
  assign o_data  = r_mem[r_rptr[AW-1:0]];
  assign w_pop   = o_valid & i_ready;
  assign w_wr    = i_push & (~o_full | w_pop);

  // Storage and pointer update; storage is cleared so the head reads 0 after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_wr) begin
        r_mem[r_wptr[AW-1:0]] <= i_data;
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/nec_cmd_ctrl.sv
// NEC IR command controller: frame qualification, key hold/repeat/release FSM
// and queued event delivery to the host over a valid/ready FIFO.
module nec_cmd_ctrl
  import nec_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 4,
  parameter int          REP_TIMEOUT = 120000,
  parameter int          ADDR_FILTER = 0,
  parameter logic [15:0] ADDR_MATCH  = 16'h0004,
  parameter int          REP_EN      = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] frame_data,
  input  logic        frame_load,
  input  logic        frame_rep,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [1:0]  evt_type,
  output logic [15:0] evt_addr,
  output logic [7:0]  evt_cmd,
  output logic [7:0]  evt_rep_cnt,
  output logic        held,
  output logic [7:0]  err_cnt,
  output logic        ovf,
  input  logic        ovf_clr
);

  localparam int            TW       = $clog2(REP_TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(REP_TIMEOUT - 1);
  localparam logic [TW-1:0] TMR_ONE  = TW'(1);

  state_t           r_state;
  logic             r_load_q;
  logic             r_rep_q;
  logic [15:0]      r_addr;
  logic [7:0]       r_cmd;
  logic [7:0]       r_rep_cnt;
  logic [TW-1:0]    r_timer;
  logic [7:0]       r_err_cnt;
  logic             r_push;
  logic [EVT_W-1:0] r_evt;
  logic             r_push_d;
  logic [EVT_W-1:0] r_evt_d;
  logic             r_ovf;

  logic             w_ld_ev;
  logic             w_rp_ev;
  logic [7:0]       w_a0;
  logic [7:0]       w_a1;
  logic [7:0]       w_c;
  logic [7:0]       w_nc;
  logic [15:0]      w_addr;
  logic             w_csum_ok;
  logic             w_addr_ok;
  logic             w_accept;
  logic             w_csum_err;
  logic [7:0]       w_rep_nxt;
  logic             w_full;
  logic             w_pop;
  logic             w_drop;
  logic [EVT_W-1:0] w_head;

  assign w_ld_ev    = frame_load & ~r_load_q;
  assign w_rp_ev    = frame_rep & ~r_rep_q;
  assign w_a0       = bit_rev8(frame_data[31:24]);
  assign w_a1       = bit_rev8(frame_data[23:16]);
  assign w_c        = bit_rev8(frame_data[15:8]);
  assign w_nc       = bit_rev8(frame_data[7:0]);
  assign w_csum_ok  = (w_c == ~w_nc);
  // Inverted second address byte means standard NEC; anything else is extended 16-bit.
  assign w_addr     = (w_a1 == ~w_a0) ? {8'h00, w_a0} : {w_a1, w_a0};
  assign w_addr_ok  = (ADDR_FILTER == 0) || (w_addr == ADDR_MATCH);
  assign w_accept   = w_ld_ev & w_csum_ok & w_addr_ok;
  assign w_csum_err = w_ld_ev & ~w_csum_ok;
  assign w_rep_nxt  = (r_rep_cnt == 8'hFF) ? r_rep_cnt : r_rep_cnt + 8'd1;

  // Edge detect, error counting and the hold/repeat/release state machine.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_load_q  <= 1'b0;
      r_rep_q   <= 1'b0;
      r_addr    <= 16'h0000;
      r_cmd     <= 8'h00;
      r_rep_cnt <= 8'h00;
      r_timer   <= '0;
      r_err_cnt <= 8'h00;
      r_push    <= 1'b0;
      r_evt     <= '0;
    end else begin
      r_load_q <= frame_load;
      r_rep_q  <= frame_rep;
      r_push   <= 1'b0;
      if (w_csum_err && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
      if (w_accept) begin
        r_state   <= ST_HELD;
        r_addr    <= w_addr;
        r_cmd     <= w_c;
        r_rep_cnt <= 8'h00;
        r_timer   <= '0;
        r_push    <= 1'b1;
        r_evt     <= {EVT_PRESS, w_addr, w_c, 8'h00};
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_timer <= '0;
          end
          ST_HELD: begin
            if (w_rp_ev) begin
              r_rep_cnt <= w_rep_nxt;
              r_timer   <= '0;
              r_push    <= (REP_EN != 0);
              r_evt     <= {EVT_REPEAT, r_addr, r_cmd, w_rep_nxt};
            end else if (r_timer == TMO_LAST) begin
              r_state <= ST_IDLE;
              r_timer <= '0;
              r_push  <= 1'b1;
              r_evt   <= {EVT_RELEASE, r_addr, r_cmd, r_rep_cnt};
            end else begin
              r_timer <= r_timer + TMR_ONE;
            end
          end
          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // Staging register between the FSM and the FIFO write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_push_d <= 1'b0;
      r_evt_d  <= '0;
    end else begin
      r_push_d <= r_push;
      r_evt_d  <= r_evt;
    end
  end

  nec_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EVT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_push_d),
    .i_data  (r_evt_d),
    .i_ready (evt_ready),
    .o_valid (evt_valid),
    .o_data  (w_head),
    .o_full  (w_full)
  );

  assign w_pop  = evt_valid & evt_ready;
  assign w_drop = r_push_d & w_full & ~w_pop;

  // Sticky overflow flag; a new drop wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (ovf_clr) begin
      r_ovf <= 1'b0;
    end else begin
      r_ovf <= r_ovf;
    end
  end

  assign {evt_type, evt_addr, evt_cmd, evt_rep_cnt} = w_head;
  assign held    = (r_state == ST_HELD);
  assign err_cnt = r_err_cnt;
  assign ovf     = r_ovf;

endmodule

// File: tb/tb_nec_cmd_ctrl.sv
// Directed bench for nec_cmd_ctrl: a main instance with a shortened repeat
// timeout and a second instance with the address filter enabled.
module tb_nec_cmd_ctrl;

  localparam int TMO = 1200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] frame_data = 32'h0;
  logic        frame_load = 1'b0;
  logic        frame_rep = 1'b0;
  logic        evt_ready = 1'b0;
  logic        f_ready = 1'b0;
  logic        ovf_clr = 1'b0;

  logic        m_valid, m_held, m_ovf;
  logic [1:0]  m_type;
  logic [15:0] m_addr;
  logic [7:0]  m_cmd, m_rep, m_err;
  logic        f_valid, f_held, f_ovf;
  logic [1:0]  f_type;
  logic [15:0] f_addr;
  logic [7:0]  f_cmd, f_rep, f_err;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  nec_cmd_ctrl #(
    .FIFO_DEPTH(4), .REP_TIMEOUT(TMO), .ADDR_FILTER(0), .ADDR_MATCH(16'h0004), .REP_EN(1)
  ) u_dut (
    .clk(clk), .rst(rst), .frame_data(frame_data), .frame_load(frame_load),
    .frame_rep(frame_rep), .evt_valid(m_valid), .evt_ready(evt_ready),
    .evt_type(m_type), .evt_addr(m_addr), .evt_cmd(m_cmd), .evt_rep_cnt(m_rep),
    .held(m_held), .err_cnt(m_err), .ovf(m_ovf), .ovf_clr(ovf_clr)
  );

  nec_cmd_ctrl #(
    .FIFO_DEPTH(4), .REP_TIMEOUT(TMO), .ADDR_FILTER(1), .ADDR_MATCH(16'h0010), .REP_EN(1)
  ) u_flt (
    .clk(clk), .rst(rst), .frame_data(frame_data), .frame_load(frame_load),
    .frame_rep(frame_rep), .evt_valid(f_valid), .evt_ready(f_ready),
    .evt_type(f_type), .evt_addr(f_addr), .evt_cmd(f_cmd), .evt_rep_cnt(f_rep),
    .held(f_held), .err_cnt(f_err), .ovf(f_ovf), .ovf_clr(ovf_clr)
  );

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  function automatic logic [31:0] mk_frame(input logic [7:0] a0, input logic [7:0] c);
    return {rev8(a0), rev8(~a0), rev8(c), rev8(~c)};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [31:0] d);
    @(negedge clk); frame_data = d; frame_load = 1'b1;
    @(negedge clk); frame_load = 1'b0;
    @(negedge clk);
  endtask

  task automatic rep_edge;
    @(negedge clk); frame_rep = 1'b1;
    @(negedge clk); frame_rep = 1'b0;
    @(negedge clk);
  endtask

  task automatic pop_one;
    @(negedge clk); evt_ready = 1'b1;
    @(negedge clk); evt_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(3);
    n_vec++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %0b want 0", m_valid); end
    n_vec++; if ({m_held, m_ovf, m_err} !== 10'd0) begin n_bad++; $display("FAIL reset_status: held=%0b ovf=%0b err=%0d want all 0", m_held, m_ovf, m_err); end
    n_vec++; if ({m_type, m_addr, m_cmd, m_rep} !== 34'd0) begin n_bad++; $display("FAIL reset_head: got %h want 0", {m_type, m_addr, m_cmd, m_rep}); end
    rst = 1'b0;
  endtask

  task automatic test_press;
    @(negedge clk); frame_data = 32'h20DF10EF; frame_load = 1'b1;
    @(posedge clk); #1;
    n_vec++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL press_lat0: valid got %0b want 0", m_valid); end
    @(posedge clk); #1;
    n_vec++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL press_lat1: valid got %0b want 0", m_valid); end
    @(posedge clk); #1;
    n_vec++; if (m_valid !== 1'b1) begin n_bad++; $display("FAIL press_lat2: valid got %0b want 1", m_valid); end
    n_vec++; if ({m_type, m_addr, m_cmd, m_rep} !== {2'b00, 16'h0004, 8'h08, 8'h00}) begin
      n_bad++; $display("FAIL press_fields: got %h want %h", {m_type, m_addr, m_cmd, m_rep}, {2'b00, 16'h0004, 8'h08, 8'h00}); end
    n_vec++; if (m_held !== 1'b1) begin n_bad++; $display("FAIL press_held: got %0b want 1", m_held); end
    @(negedge clk); frame_load = 1'b0;
    pop_one;
    n_vec++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL press_pop: valid got %0b want 0", m_valid); end
  endtask

  task automatic test_bad_checksum;
    send_frame(32'h20DF10EE);
    n_vec++; if (m_err !== 8'd1) begin n_bad++; $display("FAIL bad_err1: got %0d want 1", m_err); end
    n_vec++; if ({m_valid, m_held} !== 2'b01) begin n_bad++; $display("FAIL bad_state: valid/held got %b want 01", {m_valid, m_held}); end
    for (int i = 1; i < 300; i++) send_frame(32'h20DF10EE);
    n_vec++; if (m_err !== 8'd255) begin n_bad++; $display("FAIL bad_sat: got %0d want 255", m_err); end
    n_vec++; if ({m_valid, m_held} !== 2'b01) begin n_bad++; $display("FAIL bad_state2: valid/held got %b want 01", {m_valid, m_held}); end
  endtask

  task automatic test_repeat_release;
    send_frame(32'h20DF10EF);
    tick(1);
    n_vec++; if ({m_valid, m_type, m_addr, m_cmd, m_rep} !== {1'b1, 2'b00, 16'h0004, 8'h08, 8'h00}) begin
      n_bad++; $display("FAIL rr_press: got %h want %h", {m_valid, m_type, m_addr, m_cmd, m_rep}, {1'b1, 2'b00, 16'h0004, 8'h08, 8'h00}); end
    pop_one;
    for (int k = 1; k <= 2; k++) begin
      tick(1076);
      rep_edge;
      tick(1);
      n_vec++; if ({m_valid, m_type, m_addr, m_cmd, m_rep} !== {1'b1, 2'b01, 16'h0004, 8'h08, 8'(k)}) begin
        n_bad++; $display("FAIL rr_repeat%0d: got %h want %h", k, {m_valid, m_type, m_addr, m_cmd, m_rep}, {1'b1, 2'b01, 16'h0004, 8'h08, 8'(k)}); end
      pop_one;
    end
    tick(1076);
    @(negedge clk); frame_rep = 1'b1;
    @(posedge clk);
    @(negedge clk); frame_rep = 1'b0;
    repeat (TMO - 1) @(posedge clk);
    #1;
    n_vec++; if (m_held !== 1'b1) begin n_bad++; $display("FAIL rr_before_tmo: held got %0b want 1", m_held); end
    @(posedge clk); #1;
    n_vec++; if (m_held !== 1'b0) begin n_bad++; $display("FAIL rr_at_tmo: held got %0b want 0", m_held); end
    tick(3);
    n_vec++; if ({m_valid, m_type, m_rep} !== {1'b1, 2'b01, 8'd3}) begin
      n_bad++; $display("FAIL rr_repeat3: got %h want %h", {m_valid, m_type, m_rep}, {1'b1, 2'b01, 8'd3}); end
    pop_one;
    n_vec++; if ({m_valid, m_type, m_addr, m_cmd, m_rep} !== {1'b1, 2'b10, 16'h0004, 8'h08, 8'd3}) begin
      n_bad++; $display("FAIL rr_release: got %h want %h", {m_valid, m_type, m_addr, m_cmd, m_rep}, {1'b1, 2'b10, 16'h0004, 8'h08, 8'd3}); end
    pop_one;
    n_vec++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL rr_empty: valid got %0b want 0", m_valid); end
  endtask

  task automatic test_orphan_level;
    rep_edge;
    tick(3);
    n_vec++; if ({m_valid, m_held} !== 2'b00) begin n_bad++; $display("FAIL orphan: valid/held got %b want 00", {m_valid, m_held}); end
    @(negedge clk); frame_data = 32'h20DF10EF; frame_load = 1'b1;
    tick(5000);
    frame_load = 1'b0;
    tick(3);
    n_vec++; if ({m_valid, m_type, m_cmd} !== {1'b1, 2'b00, 8'h08}) begin
      n_bad++; $display("FAIL level_press: got %h want %h", {m_valid, m_type, m_cmd}, {1'b1, 2'b00, 8'h08}); end
    pop_one;
    n_vec++; if ({m_valid, m_type, m_rep} !== {1'b1, 2'b10, 8'd0}) begin
      n_bad++; $display("FAIL level_single: got %h want %h", {m_valid, m_type, m_rep}, {1'b1, 2'b10, 8'd0}); end
    pop_one;
    n_vec++; if (m_valid !== 1'b0) begin n_bad++; $display("FAIL level_empty: valid got %0b want 0", m_valid); end
  endtask

  task automatic test_overflow;
    evt_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send_frame(mk_frame(8'h04, 8'(i)));
    tick(3);
    n_vec++; if ({m_ovf, m_valid} !== 2'b11) begin n_bad++; $display("FAIL ovf_set: ovf/valid got %b want 11", {m_ovf, m_valid}); end
    for (int i = 1; i <= 4; i++) begin
      n_vec++; if ({m_valid, m_type, m_addr, m_cmd} !== {1'b1, 2'b00, 16'h0004, 8'(i)}) begin
        n_bad++; $display("FAIL ovf_drain%0d: got %h want %h", i, {m_valid, m_type, m_addr, m_cmd}, {1'b1, 2'b00, 16'h0004, 8'(i)}); end
      pop_one;
    end
    n_vec++; if ({m_valid, m_ovf} !== 2'b01) begin n_bad++; $display("FAIL ovf_empty: valid/ovf got %b want 01", {m_valid, m_ovf}); end
    @(negedge clk); ovf_clr = 1'b1;
    @(negedge clk); ovf_clr = 1'b0;
    n_vec++; if (m_ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_clr: got %0b want 0", m_ovf); end
    tick(TMO);
    n_vec++; if ({m_valid, m_type, m_cmd, m_held} !== {1'b1, 2'b10, 8'h05, 1'b0}) begin
      n_bad++; $display("FAIL ovf_release: got %h want %h", {m_valid, m_type, m_cmd, m_held}, {1'b1, 2'b10, 8'h05, 1'b0}); end
    pop_one;
  endtask

  task automatic test_filter;
    send_frame(32'h20DF10EF);
    tick(1);
    n_vec++; if ({f_valid, f_held} !== 2'b00) begin n_bad++; $display("FAIL flt_drop: valid/held got %b want 00", {f_valid, f_held}); end
    send_frame(32'h08F710EF);
    tick(1);
    n_vec++; if ({f_valid, f_type, f_addr, f_cmd, f_rep, f_held} !== {1'b1, 2'b00, 16'h0010, 8'h08, 8'h00, 1'b1}) begin
      n_bad++; $display("FAIL flt_match: got %h want %h", {f_valid, f_type, f_addr, f_cmd, f_rep, f_held}, {1'b1, 2'b00, 16'h0010, 8'h08, 8'h00, 1'b1}); end
  endtask

  task automatic test_reset_held;
    n_vec++; if ({m_valid, m_held} !== 2'b11) begin n_bad++; $display("FAIL rst_pre: valid/held got %b want 11", {m_valid, m_held}); end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    n_vec++; if ({m_valid, m_held, m_err, m_ovf} !== 11'd0) begin
      n_bad++; $display("FAIL rst_main: valid=%0b held=%0b err=%0d ovf=%0b want all 0", m_valid, m_held, m_err, m_ovf); end
    n_vec++; if ({f_valid, f_held, f_err, f_ovf} !== 11'd0) begin
      n_bad++; $display("FAIL rst_flt: valid=%0b held=%0b err=%0d ovf=%0b want all 0", f_valid, f_held, f_err, f_ovf); end
    tick(TMO + 100);
    n_vec++; if ({m_valid, m_held} !== 2'b00) begin n_bad++; $display("FAIL rst_no_release: valid/held got %b want 00", {m_valid, m_held}); end
  endtask

  initial begin
    test_reset();
    test_press();
    test_bad_checksum();
    test_repeat_release();
    test_orphan_level();
    test_overflow();
    test_filter();
    test_reset_held();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/nec_cmd_ctrl.md
Name: nec_cmd_ctrl

Overview:
- Controller behind the NEC IR decoder. It consumes the decoder's 32-bit frame word and its load/repeat strobes.
- Qualifies each frame by checksum and optional address filter.
- Runs the key hold/repeat/release state machine.
- Queues press/repeat/release events into a small FIFO with a valid/ready handshake, for the host register block.
- clk is the same 1 MHz (1 us) clock that times the decoder, so all time parameters are in clk cycles.

Parameters:
- FIFO_DEPTH, 4, event FIFO entries; power of 2, at least 2.
- REP_TIMEOUT, 120000, cycles without a repeat code before a held key is released.
- ADDR_FILTER, 0, 1 = drop valid frames whose address is not ADDR_MATCH.
- ADDR_MATCH, 16'h0004, address accepted when ADDR_FILTER = 1.
- REP_EN, 1, 1 = emit a repeat event on each accepted repeat code; 0 = only refresh the timer.

Ports:
- clk, in, 1, clock (1 MHz).
- rst, in, 1, reset: synchronous, active-high.
- frame_data, in, 32, decoder shift register; first received bit in bit 31.
- frame_load, in, 1, decoder load level; may stay high for many cycles.
- frame_rep, in, 1, decoder repeat level.
- evt_valid, out, 1, FIFO head valid.
- evt_ready, in, 1, consumer accepts the head.
- evt_type, out, 2, 00 press, 01 repeat, 10 release.
- evt_addr, out, 16, decoded address.
- evt_cmd, out, 8, decoded command.
- evt_rep_cnt, out, 8, repeat count at the time of the event.
- held, out, 1, state is HELD.
- err_cnt, out, 8, saturating checksum-failure count.
- ovf, out, 1, sticky FIFO overflow flag.
- ovf_clr, in, 1, clears ovf.

Behaviour:
- Reset values: all outputs 0, FIFO empty, state IDLE, timer 0, edge registers 0.
- Edge detect: frame_load and frame_rep are each registered; ld_ev = frame_load & ~load_q, rp_ev = frame_rep & ~rep_q. Only edges are acted on.
- Decode on ld_ev, from frame_data sampled in the same cycle; rev() = bit reversal of a byte:
  - a0 = rev([31:24]), a1 = rev([23:16]), c = rev([15:8]), nc = rev([7:0]).
  - Checksum ok iff c == ~nc; otherwise err_cnt++ (saturate at 255), no event, state unchanged.
  - addr = {8'h00, a0} if a1 == ~a0, else {a1, a0} (extended NEC).
  - If ADDR_FILTER = 1 and addr != ADDR_MATCH: frame dropped silently, state unchanged.
- State machine (IDLE, HELD):
  - IDLE + accepted frame -> HELD. Latch addr and cmd, rep_cnt = 0, timer = 0, push press.
  - IDLE + rp_ev -> ignored (orphan repeat); no count, no event.
  - HELD + accepted frame (any code) -> stay HELD. Relatch, rep_cnt = 0, timer = 0, push press. No release is emitted for the old key.
  - HELD + rp_ev -> rep_cnt++ (saturate at 255), timer = 0, push repeat if REP_EN.
  - HELD + timer == REP_TIMEOUT-1 with no event -> IDLE, push release carrying the latched addr/cmd and final rep_cnt.
  - Timer increments every cycle in HELD; width is $clog2(REP_TIMEOUT).
- Priority within one cycle: accepted frame > rp_ev > timeout. At most one FIFO push per cycle.
- Latency: with the FIFO empty, evt_valid is high 2 cycles after the first edge at which frame_load is sampled high.
- FIFO:
  - Pop when evt_valid & evt_ready. Head fields are stable while evt_valid & ~evt_ready.
  - Simultaneous push and pop when full is allowed; no loss.
  - Push when full and no pop: event dropped, ovf = 1.
  - ovf_clr clears ovf. If ovf_clr and a new overflow occur in the same cycle, ovf stays 1.
  - Pointers wrap modulo FIFO_DEPTH; an extra count bit distinguishes full from empty.
- rst mid-HELD or with the FIFO non-empty: everything returns to reset values. No release event is generated.

Decomposition:
- Package nec_pkg holds:
  - event type constants EVT_PRESS, EVT_REPEAT, EVT_RELEASE;
  - state encodings;
  - a byte bit-reverse function;
  - the event record width (34 bits: type, addr, cmd, rep_cnt).
- One sub-module, nec_evt_fifo: synchronous FIFO with parameterised depth and width, valid/ready out, full flag.

Test Plan:
- Press: frame_data = 32'h20DF10EF, frame_load rises -> 2 cycles later one event: type 00, addr 16'h0004, cmd 8'h08, rep_cnt 0; held = 1.
- Bad checksum: frame_data = 32'h20DF10EE with a load edge -> no event, err_cnt = 1, held unchanged. Repeat 300 times -> err_cnt saturates at 255.
- Repeat/release: press as above, then 3 frame_rep edges spaced 108000 cycles -> repeat events with rep_cnt 1, 2, 3. Then no further edges -> release event with rep_cnt 3 exactly REP_TIMEOUT cycles after the last repeat edge; held = 0.
- Orphan and level: frame_rep edge in IDLE -> no event. frame_load held high 5000 cycles -> exactly one press.
- Overflow: evt_ready = 0, generate 5 presses -> 4 events queued, ovf = 1. Then evt_ready = 1 -> the 4 events drain in order. Pulse ovf_clr -> ovf = 0.
- Reset/filter: ADDR_FILTER = 1, ADDR_MATCH = 16'h0010, frame 32'h20DF10EF -> no event. Separately, assert rst while HELD with 2 events queued -> evt_valid = 0, held = 0, no release emitted.
